tmds_rx_align_decode: RTL



---
 rtl/tmds_rx_pkg.sv | 23 ++
 rtl/tmds_symbol_decode.sv | 35 +++
 rtl/tmds_rx_align_decode.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tmds_rx_pkg.sv
// Shared TMDS receive definitions: control tokens, aligner states,
// offset width and the offset-advance helper.
package tmds_rx_pkg;

    localparam int OFS_W = 4;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Bit offsets run 0..9 and wrap.
    function automatic logic [OFS_W-1:0] ofs_inc(input logic [OFS_W-1:0] ofs);
        return (ofs == OFS_W'(9)) ? '0 : ofs + 1'b1;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: control-token match plus
// 10b->8b data decode of one aligned symbol.
module tmds_symbol_decode
    import tmds_rx_pkg::*;
(
    input  logic [9:0] w,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] d;

    always_comb begin
        is_token = 1'b1;
        ctrl     = 2'b00;
        unique case (1'b1)
            (w == TOK_C00): ctrl = 2'b00;
            (w == TOK_C01): ctrl = 2'b01;
            (w == TOK_C10): ctrl = 2'b10;
            (w == TOK_C11): ctrl = 2'b11;
            default:        is_token = 1'b0;
        endcase
    end

    always_comb begin
        d       = w[9] ? ~w[7:0] : w[7:0];
        data    = '0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_rx_align_decode.sv
// TMDS channel receiver: token-run word aligner and symbol decode.
// Optional TMDS_RELOCK_CNT_EN adds a saturating lock-loss counter.
module tmds_rx_align_decode
    import tmds_rx_pkg::*;
#(
    parameter int LOCK_RUN    = 8,
    parameter int DWELL       = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic             i_pixclk,
    input  logic             i_rst_n,
    input  logic [9:0]       i_raw,
    output logic [7:0]       o_data,
    output logic [1:0]       o_ctrl,
    output logic             o_de,
    output logic             o_locked,
    output logic [OFS_W-1:0] o_offset
`ifdef TMDS_RELOCK_CNT_EN
    ,
    output logic [7:0]       o_relock_cnt
`endif
);

    localparam int RUN_W = $clog2(LOCK_RUN + 1);
    localparam int DWL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int WDG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_RUN);
    localparam logic [DWL_W-1:0] DWL_MAX = DWL_W'(DWELL - 1);
    localparam logic [WDG_W-1:0] WDG_MAX = WDG_W'(WDOG_CYCLES - 1);

    state_t             state, state_n;
    logic [19:0]        hist;
    logic [19:0]        shifted;
    logic [9:0]         w;
    logic [OFS_W-1:0]   offset, offset_n;
    logic [DWL_W-1:0]   dwell, dwell_n;
    logic [RUN_W-1:0]   run, run_n;
    logic [WDG_W-1:0]   wdog, wdog_n;
    logic               expire;
    logic               is_token;
    logic [1:0]         ctrl;
    logic [7:0]         data;

    assign shifted = hist >> offset;
    assign w       = shifted[9:0];

    tmds_symbol_decode u_dec (
        .w        (w),
        .is_token (is_token),
        .ctrl     (ctrl),
        .data     (data)
    );

    always_comb begin
        state_n  = state;
        offset_n = offset;
        dwell_n  = dwell;
        run_n    = run;
        wdog_n   = wdog;
        expire   = 1'b0;
        unique case (state)
            SEARCH: begin
                if (is_token) begin
                    state_n = VERIFY;
                    run_n   = RUN_W'(1);
                    dwell_n = '0;
                end else if (dwell == DWL_MAX) begin
                    dwell_n  = '0;
                    offset_n = ofs_inc(offset);
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            VERIFY: begin
                if (is_token) begin
                    run_n = run + 1'b1;
                    if (run_n == RUN_MAX) begin
                        state_n = LOCKED;
                        wdog_n  = '0;
                    end
                end else begin
                    state_n = SEARCH;
                    dwell_n = '0;
                    run_n   = '0;
                end
            end
            LOCKED: begin
                if (!is_token) begin
                    run_n = '0;
                end else if (run != RUN_MAX) begin
                    run_n = run + 1'b1;
                end
                // A full token run keeps the link alive even at expiry.
                if (is_token && run_n == RUN_MAX) begin
                    wdog_n = '0;
                end else if (wdog == WDG_MAX) begin
                    state_n  = SEARCH;
                    offset_n = ofs_inc(offset);
                    wdog_n   = '0;
                    run_n    = '0;
                    dwell_n  = '0;
                    expire   = 1'b1;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            default: begin
                state_n = SEARCH;
            end
        endcase
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist   <= '0;
            state  <= SEARCH;
            offset <= '0;
            dwell  <= '0;
            run    <= '0;
            wdog   <= '0;
        end else begin
            hist   <= {i_raw, hist[19:10]};
            state  <= state_n;
            offset <= offset_n;
            dwell  <= dwell_n;
            run    <= run_n;
            wdog   <= wdog_n;
        end
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_de   <= 1'b0;
            o_data <= '0;
            o_ctrl <= '0;
        end else if (state == LOCKED && is_token) begin
            o_de   <= 1'b0;
            o_data <= '0;
            o_ctrl <= ctrl;
        end else if (state == LOCKED) begin
            o_de   <= 1'b1;
            o_data <= data;
        end else begin
            o_de   <= 1'b0;
            o_data <= '0;
            o_ctrl <= '0;
        end
    end

    assign o_locked = (state == LOCKED);
    assign o_offset = offset;

`ifdef TMDS_RELOCK_CNT_EN
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_relock_cnt <= '0;
        end else if (expire && o_relock_cnt != 8'hFF) begin
            o_relock_cnt <= o_relock_cnt + 1'b1;
        end
    end
`endif

endmodule
